mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles under a start/busy/done handshake; the core stalls on busy.
- Also services MTHI/MTLO writes.
- Adds width generalisation, signed/unsigned modes, defined divide-by-zero results and clock-enable stalling.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clk_enable  input  1  when 0, all registered state holds (global stall)
start  input  1  request; sampled on a clk edge with clk_enable=1
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
in_a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
in_b  input  WIDTH  rt operand: multiplier or divisor
busy  output  1  1 while an operation is in flight
done  output  1  one-cycle pulse when HI/LO have just been updated by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Applies even mid-operation; the in-flight result is discarded.
- All transitions occur only on rising clk edges with clk_enable=1. With clk_enable=0, state, counter, hi, lo and done hold; a done pulse is stretched until the next enabled edge.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 and op in {0..3}: latch operands as magnitudes (absolute value for signed ops, raw for unsigned); record the result sign; counter=WIDTH-1; go to RUN.
  - start=1, op=4: hi<=in_a in that edge. op=5: lo<=in_a. Stay IDLE, no busy, no done.
  - op 6-7, or start=0: no effect.
- RUN:
  - One iteration per enabled edge; exactly WIDTH edges.
  - Multiply: radix-2 shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per edge, WIDTH+1-bit partial remainder.
  - Leave RUN when counter=0.
- FIX (one edge):
  - Apply sign correction.
  - Multiply: {hi,lo} = 2*WIDTH-bit product (negated if signs differ, signed op).
  - Divide: lo=quotient, negated if signs differ; hi=remainder, carrying the sign of the dividend.
  - done<=1 for exactly one enabled cycle after this edge; go to IDLE.
- busy=1 in RUN and FIX, combinational from state. hi/lo hold their old values until the FIX edge.
- Latency: start sampled at edge k; hi/lo written at edge k+WIDTH+1; done high during the following cycle; a new start is accepted at edge k+WIDTH+2.
- start while busy=1 is ignored, including MTHI/MTLO; the core must hold it until busy=0.
- Divide by zero, DIV or DIVU: lo = all ones, hi = in_a (original dividend, unmodified). Still takes full latency.
- Signed overflow, DIV of most-negative by -1: lo = most-negative value, hi=0. This falls out of unsigned magnitude arithmetic; no special case.
- Arithmetic is modulo 2^WIDTH per register. No exceptions are raised.

Test Plan:
- Reset mid-RUN: MULT 7 x 6; assert reset=0 at cycle 10 -> busy=0, hi=0, lo=0 immediately; no done follows; a fresh MULTU 3 x 5 later gives lo=15, hi=0.
- Signed/unsigned multiply: MULT 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE. done at edge k+33, busy high for 33 cycles.
- Signed divide: DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2.
- Corner divides: DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake and stall:
  - start MULT while busy -> ignored; result is that of the first op only.
  - Hold clk_enable=0 for 5 cycles mid-RUN -> done arrives 5 cycles later with the correct value.
  - MTHI 0xA5A5A5A5 in IDLE -> hi updates next edge, busy and done stay 0.
- Parametrisation: WIDTH=8, MULT 0x80 x 0x80 -> hi=0x40, lo=0x00, done at edge k+9. DIV 0x80 / 0xFF -> lo=0x80, hi=0.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per enabled clock, then a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     other_q, other_d;
    logic                 isDiv_q, isDiv_d;
    logic                 negRes_q, negRes_d;
    logic                 remNeg_q, remNeg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 opSigned;
    logic                 aNeg;
    logic                 bNeg;
    logic                 bZero;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH+1:0]     divShift;
    logic [WIDTH+1:0]     divDiff;
    logic                 divGeq;
    logic [2*WIDTH-1:0]   mulFix;
    logic [WIDTH-1:0]     quotFix;
    logic [WIDTH-1:0]     remFix;

    // Operand magnitudes and per-step datapath (multiply adder, divide trial subtract).
    always_comb begin
        opSigned = ~op[0];
        aNeg     = opSigned & in_a[WIDTH-1];
        bNeg     = opSigned & in_b[WIDTH-1];
        bZero    = (in_b == {WIDTH{1'b0}});
        magA     = aNeg ? (~in_a + 1'b1) : in_a;
        magB     = bNeg ? (~in_b + 1'b1) : in_b;

        addend   = acc_q[0] ? other_q : {WIDTH{1'b0}};
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

        divShift = {rem_q, acc_q[WIDTH-1]};
        divDiff  = divShift - {2'b00, other_q};
        divGeq   = ~divDiff[WIDTH+1];

        mulFix   = negRes_q ? (~acc_q + 1'b1) : acc_q;
        quotFix  = negRes_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        remFix   = remNeg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    end

    // Next-state logic; done defaults low so it pulses for one enabled cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        other_d  = other_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        remNeg_d = remNeg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        // Dividing by zero keeps the quotient positive so lo ends up all ones
                        // and the sign-corrected remainder reproduces the original dividend.
                        isDiv_d  = op[1];
                        acc_d    = {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
                        other_d  = op[1] ? magB : magA;
                        rem_d    = {(WIDTH+1){1'b0}};
                        negRes_d = (aNeg ^ bNeg) & ~(op[1] & bZero);
                        remNeg_d = aNeg;
                        count_d  = CW'(WIDTH-1);
                        state_d  = RUN;
                    end else if (op[1:0] == 2'b00) begin
                        hi_d = in_a;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d = in_a;
                    end
                end
            end
            RUN: begin
                if (isDiv_q) begin
                    acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], divGeq};
                    rem_d = divGeq ? divDiff[WIDTH:0] : divShift[WIDTH:0];
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                end
                if (count_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = quotFix;
                    hi_d = remFix;
                end else begin
                    hi_d = mulFix[2*WIDTH-1:WIDTH];
                    lo_d = mulFix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            other_q  <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            remNeg_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            other_q  <= other_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            remNeg_q <= remNeg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: a 32-bit and an 8-bit instance,
// directed vectors push expected {hi,lo}; monitors pop on each done pulse.
module tb_mips_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        ce32, start32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        ce8, start8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks = 0;
    int failures = 0;
    logic [63:0] expQ32[$];
    logic [15:0] expQ8[$];

    mips_muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(resetN), .clk_enable(ce32), .start(start32), .op(op32),
        .in_a(a32), .in_b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mips_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(resetN), .clk_enable(ce8), .start(start8), .op(op8),
        .in_a(a8), .in_b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors: a done pulse is consumed on the enabled edge, so only count it when enabled.
    always @(negedge clk) begin
        if (resetN && done32 && ce32) begin
            if (expQ32.size() == 0) begin
                checkOutput("unexpectedDone32", {hi32, lo32}, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                checkOutput("result32", {hi32, lo32}, expQ32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (resetN && done8 && ce8) begin
            if (expQ8.size() == 0) begin
                checkOutput("unexpectedDone8", {48'd0, hi8, lo8}, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                checkOutput("result8", {48'd0, hi8, lo8}, {48'd0, expQ8.pop_front()});
            end
        end
    end

    task automatic driveIn(input bit sel, input logic st, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            start8 = st; op8 = o; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = st; op32 = o; a32 = a; b32 = b;
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input int expLat,
                                 input int stallAt, input int stallLen, input bit intrude);
        int  n;
        bit  seen;
        driveIn(sel, 1'b1, o, a, b);
        @(posedge clk);
        if (sel) expQ8.push_back({expHi[7:0], expLo[7:0]});
        else     expQ32.push_back({expHi, expLo});
        #1;
        driveIn(sel, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("busyAfterStart", 64'(sel ? busy8 : busy32), 64'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            if (intrude && n == 3) driveIn(sel, 1'b1, 3'd0, 32'd5, 32'd5);
            if (intrude && n == 4) driveIn(sel, 1'b0, 3'd0, 32'd0, 32'd0);
            @(posedge clk);
            #1;
            n++;
            if (stallLen > 0 && n == stallAt) begin
                if (sel) ce8 = 1'b0; else ce32 = 1'b0;
            end
            if (stallLen > 0 && n == stallAt + stallLen) begin
                if (sel) ce8 = 1'b1; else ce32 = 1'b1;
            end
            seen = sel ? done8 : done32;
        end
        checkOutput("doneLatency", 64'(n), 64'(expLat));
        if (seen) begin
            checkOutput("busyAtDone", 64'(sel ? busy8 : busy32), 64'd0);
            @(posedge clk);
            #1;
            checkOutput("donePulseWidth", 64'(sel ? done8 : done32), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCount;
        resetN = 1'b0;
        ce32 = 1'b1; ce8 = 1'b1;
        driveIn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        driveIn(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", 64'(busy32), 64'd0);
        checkOutput("resetDone", 64'(done32), 64'd0);
        checkOutput("resetHiLo", {hi32, lo32}, 64'd0);
        checkOutput("resetHiLo8", {48'd0, hi8, lo8}, 64'd0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // MTHI / MTLO / reserved op in IDLE
        driveIn(1'b0, 1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0);
        @(posedge clk);
        #1;
        driveIn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("mthiHi", 64'(hi32), 64'hA5A5_A5A5);
        checkOutput("mthiBusy", 64'(busy32), 64'd0);
        checkOutput("mthiDone", 64'(done32), 64'd0);
        driveIn(1'b0, 1'b1, 3'd5, 32'h5A5A_5A5A, 32'd0);
        @(posedge clk);
        #1;
        driveIn(1'b1 ^ 1'b1, 1'b1, 3'd6, 32'h1111_1111, 32'h2222_2222);
        checkOutput("mtloLo", 64'(lo32), 64'h5A5A_5A5A);
        @(posedge clk);
        #1;
        driveIn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("reservedOpHiLo", {hi32, lo32}, 64'hA5A5_A5A5_5A5A_5A5A);
        checkOutput("reservedOpBusy", 64'(busy32), 64'd0);

        // 32-bit multiply / divide vectors
        applyStimulus(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 0, 0, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 33, 0, 0, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'hFFFF_FFFD, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_F448, 38, 10, 5, 1'b0);

        // Reset during RUN discards the in-flight multiply
        driveIn(1'b0, 1'b1, 3'd0, 32'd7, 32'd6);
        @(posedge clk);
        #1;
        driveIn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("midResetBusy", 64'(busy32), 64'd0);
        checkOutput("midResetHiLo", {hi32, lo32}, 64'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done32) doneCount++;
        end
        checkOutput("noDoneAfterReset", 64'(doneCount), 64'd0);
        applyStimulus(1'b0, 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 33, 0, 0, 1'b0);

        // 8-bit instance
        applyStimulus(1'b1, 3'd0, 32'h80, 32'h80, 32'h40, 32'h00, 9, 0, 0, 1'b0);
        applyStimulus(1'b1, 3'd2, 32'h80, 32'hFF, 32'h00, 32'h80, 9, 0, 0, 1'b0);
        applyStimulus(1'b1, 3'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 9, 0, 0, 1'b0);
        applyStimulus(1'b1, 3'd2, 32'hF9, 32'h02, 32'hFF, 32'hFD, 9, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue32Drained", 64'(expQ32.size()), 64'd0);
        checkOutput("queue8Drained", 64'(expQ8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
